bus_downsizer: RTL

- Parametrised successor to the fixed word/byte/strobe types: converts one WIDE_BYTES-wide bus request (word + byte strobe) into a sequence of NARROW_BYTES-wide beats on a narrower memory or peripheral bus.
- Reassembles read data and splits writes by strobe.
- Sits between the core's data bus and narrow devices such as byte-wide ROM, 16-bit SRAM and UART register files.
- Both sides use the codebase's valid/ready bus protocol: the requester holds its request while valid is high; ready is a one-cycle completion pulse.

---
 rtl/bus_downsizer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bus_downsizer.sv
// bus_downsizer
//   Splits one WIDE_BYTES-wide host request (word + byte strobe) into a
//   sequence of NARROW_BYTES-wide device beats. Reads cover every beat and are
//   reassembled into host_rdata. Writes issue only the beats whose strobe
//   slice is non-zero.
//
//   State table
//     state   | meaning
//     --------+-----------------------------------------------------------
//     S_IDLE  | waiting for host_valid; latches the request on acceptance
//     S_ISSUE | dev_valid high for beat idx_q until dev_ready
//     S_DONE  | one-cycle host_ready pulse with the assembled read data
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   host_valid      host request present (held until host_ready)
//   host_ready      one-cycle completion pulse to the host
//   host_address    byte address of the host request
//   host_wstrobe    byte write enables, all-zero means read
//   host_wdata      host write data
//   host_rdata      assembled read data, valid while host_ready=1
//   dev_valid       narrow beat request
//   dev_ready       narrow beat completion
//   dev_address     byte address of the current beat
//   dev_wstrobe     byte enables of the current beat
//   dev_wdata       write data of the current beat
//   dev_rdata       beat read data, sampled when dev_ready=1

module bus_downsizer #(
  parameter int WIDE_BYTES   = 4,
  parameter int NARROW_BYTES = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      host_valid,
  output logic                      host_ready,
  input  logic [ADDR_WIDTH-1:0]     host_address,
  input  logic [WIDE_BYTES-1:0]     host_wstrobe,
  input  logic [8*WIDE_BYTES-1:0]   host_wdata,
  output logic [8*WIDE_BYTES-1:0]   host_rdata,
  output logic                      dev_valid,
  input  logic                      dev_ready,
  output logic [ADDR_WIDTH-1:0]     dev_address,
  output logic [NARROW_BYTES-1:0]   dev_wstrobe,
  output logic [8*NARROW_BYTES-1:0] dev_wdata,
  input  logic [8*NARROW_BYTES-1:0] dev_rdata
);

  localparam int RATIO = WIDE_BYTES / NARROW_BYTES;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int NBITS = 8 * NARROW_BYTES;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WIDE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [WIDE_BYTES-1:0]     wstrb_q, wstrb_d;
  logic [8*WIDE_BYTES-1:0]   wdata_q, wdata_d;
  logic [8*WIDE_BYTES-1:0]   rdata_q, rdata_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  logic                      is_write;
  logic [IDX_W-1:0]          first_idx;
  logic [IDX_W-1:0]          next_idx;
  logic                      has_next;
  logic [NARROW_BYTES-1:0]   cur_strb;
  logic [NBITS-1:0]          cur_wdata;

  assign is_write = |wstrb_q;

  // First beat of an incoming request: lowest beat with any strobe bit set,
  // which falls back to beat 0 for a read (all strobes zero).
  always_comb begin
    first_idx = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (|host_wstrobe[i*NARROW_BYTES +: NARROW_BYTES]) first_idx = IDX_W'(i);
    end
  end

  // Next beat after idx_q: every beat for reads, only strobed beats for writes.
  always_comb begin
    next_idx = idx_q;
    has_next = 1'b0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i > int'(idx_q) && (!is_write || (|wstrb_q[i*NARROW_BYTES +: NARROW_BYTES]))) begin
        next_idx = IDX_W'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    cur_strb  = '0;
    cur_wdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_strb  = wstrb_q[i*NARROW_BYTES +: NARROW_BYTES];
        cur_wdata = wdata_q[i*NBITS +: NBITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (host_valid) begin
          base_d  = host_address & ALIGN_MASK;
          wstrb_d = host_wstrobe;
          wdata_d = host_wdata;
          rdata_d = '0;
          idx_d   = first_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dev_ready) begin
          if (!is_write) begin
            for (int i = 0; i < RATIO; i++) begin
              if (idx_q == IDX_W'(i)) rdata_d[i*NBITS +: NBITS] = dev_rdata;
            end
          end
          // idx_q stays on the last beat when finishing, so it never wraps.
          if (has_next) idx_d = next_idx;
          else          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
    end
  end

  // All outputs come from registers, so nothing on the host side reaches the
  // device side in the same cycle.
  assign dev_valid   = (state_q == S_ISSUE);
  assign dev_address = base_q + ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(NARROW_BYTES);
  assign dev_wstrobe = cur_strb;
  assign dev_wdata   = cur_wdata;
  assign host_ready  = (state_q == S_DONE);
  assign host_rdata  = rdata_q;

endmodule
